window_control: RTL and testbench

//  Owns the SPARC V8 window state: CWP (current window pointer), WIM (window invalid mask) and ET (enable traps).

---
 rtl/win_pkg.sv | 28 ++
 rtl/win_mod_step.sv | 25 ++
 rtl/window_control.sv | 170 +++++++++++++++++
 tb/tb_window_control.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/win_pkg.sv
// Shared constants for the SPARC V8 window controller: command and trap-type encodings
// and the sequencer state type.
package win_pkg;

    localparam int unsigned NWIN  = 4;
    localparam int unsigned CWP_W = $clog2(NWIN);

    localparam logic [2:0] CMD_NOP     = 3'b000;
    localparam logic [2:0] CMD_SAVE    = 3'b001;
    localparam logic [2:0] CMD_RESTORE = 3'b010;
    localparam logic [2:0] CMD_WRWIM   = 3'b011;
    localparam logic [2:0] CMD_TRAPENT = 3'b100;
    localparam logic [2:0] CMD_RETT    = 3'b101;
    localparam logic [2:0] CMD_WRCWP   = 3'b110;
    localparam logic [2:0] CMD_RSVD    = 3'b111;

    localparam logic [1:0] TT_NONE = 2'b00;
    localparam logic [1:0] TT_OVF  = 2'b01;
    localparam logic [1:0] TT_UNF  = 2'b10;
    localparam logic [1:0] TT_ERR  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StDone
    } win_state_e;

endpackage

// File: rtl/win_mod_step.sv
// Combinational window step: CWP +/- 1 modulo NWIN and the WIM bit of the resulting window.
module win_mod_step #(
    parameter int unsigned NWIN = 4
) (
    input  logic [$clog2(NWIN)-1:0] cwp_i,
    input  logic                    inc_i,
    input  logic [NWIN-1:0]         wim_i,
    output logic [$clog2(NWIN)-1:0] nxt_o,
    output logic                    invalid_o
);

    localparam int unsigned CW = $clog2(NWIN);
    localparam logic [CW-1:0] LAST = CW'(NWIN - 1);

    // Explicit wrap so a non-power-of-two NWIN still steps correctly.
    always_comb begin
        if (inc_i) begin
            nxt_o = (cwp_i == LAST) ? '0 : cwp_i + 1'b1;
        end else begin
            nxt_o = (cwp_i == '0) ? LAST : cwp_i - 1'b1;
        end
        invalid_o = wim_i[nxt_o];
    end

endmodule

// File: rtl/window_control.sv
// SPARC V8 window state owner (CWP, WIM, ET) executing window commands over a Req/Ack handshake.
// Define WINCTL_STATS_EN to add saturating overflow/underflow trap counters (OvfCnt, UnfCnt).
module window_control #(
    parameter int unsigned     NWIN    = 4,
    parameter logic [NWIN-1:0] WIM_RST = NWIN'(4'b0010)
) (
    input  logic                    Clk,
    input  logic                    Clr,
    input  logic                    Req,
    input  logic [2:0]              Cmd,
    input  logic [3:0]              DataIn,
    output logic                    Ack,
    output logic                    Busy,
    output logic [$clog2(NWIN)-1:0] CwpOut,
    output logic [NWIN-1:0]         WimOut,
    output logic                    EtOut,
    output logic                    WinTrap,
    output logic [1:0]              TrapType,
`ifdef WINCTL_STATS_EN
    output logic [15:0]             OvfCnt,
    output logic [15:0]             UnfCnt,
`endif
    output logic                    ErrMode
);

    import win_pkg::*;

    localparam int unsigned CW = $clog2(NWIN);

    win_state_e      state_q, state_d;
    logic [2:0]      cmd_q, cmd_d;
    logic [3:0]      data_q, data_d;
    logic [CW-1:0]   cwp_q, cwp_d;
    logic [CW-1:0]   nxt_q, nxt_d;
    logic [NWIN-1:0] wim_q, wim_d;
    logic            et_q, et_d;
    logic            trap_q, trap_d;
    logic [1:0]      tt_q, tt_d;
    logic            err_q, err_d;

    logic            step_inc;
    logic [CW-1:0]   step_nxt;
    logic            step_inv;

    assign step_inc = (cmd_q == CMD_RESTORE) || (cmd_q == CMD_RETT);

    win_mod_step #(
        .NWIN (NWIN)
    ) u_step (
        .cwp_i     (cwp_q),
        .inc_i     (step_inc),
        .wim_i     (wim_q),
        .nxt_o     (step_nxt),
        .invalid_o (step_inv)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        cwp_d   = cwp_q;
        nxt_d   = nxt_q;
        wim_d   = wim_q;
        et_d    = et_q;
        trap_d  = trap_q;
        tt_d    = tt_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (Req && !err_q) begin
                    cmd_d   = Cmd;
                    data_d  = DataIn;
                    state_d = StEval;
                end
            end
            StEval: begin
                nxt_d  = step_nxt;
                trap_d = 1'b0;
                tt_d   = TT_NONE;
                case (cmd_q)
                    CMD_SAVE:    if (step_inv) begin trap_d = 1'b1; tt_d = TT_OVF; end
                    CMD_RESTORE: if (step_inv) begin trap_d = 1'b1; tt_d = TT_UNF; end
                    // RETT with ET=1 is illegal and retires as a NOP, so no WIM check.
                    CMD_RETT:    if (!et_q && step_inv) begin trap_d = 1'b1; tt_d = TT_UNF; end
                    CMD_TRAPENT: if (!et_q) begin trap_d = 1'b1; tt_d = TT_ERR; end
                    default: ;
                endcase
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
                if (trap_q) begin
                    if (tt_q == TT_ERR) err_d = 1'b1;
                end else begin
                    case (cmd_q)
                        CMD_SAVE, CMD_RESTORE: cwp_d = nxt_q;
                        CMD_TRAPENT: begin cwp_d = nxt_q; et_d = 1'b0; end
                        CMD_RETT:    if (!et_q) begin cwp_d = nxt_q; et_d = 1'b1; end
                        CMD_WRWIM:   wim_d = data_q[NWIN-1:0];
                        CMD_WRCWP:   cwp_d = data_q[CW-1:0];
                        default: ;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= StIdle;
            cmd_q   <= CMD_NOP;
            data_q  <= '0;
            cwp_q   <= '0;
            nxt_q   <= '0;
            wim_q   <= WIM_RST;
            et_q    <= 1'b1;
            trap_q  <= 1'b0;
            tt_q    <= TT_NONE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            cwp_q   <= cwp_d;
            nxt_q   <= nxt_d;
            wim_q   <= wim_d;
            et_q    <= et_d;
            trap_q  <= trap_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
        end
    end

    assign Ack      = (state_q == StDone);
    assign Busy     = (state_q != StIdle);
    assign WinTrap  = Ack && trap_q;
    assign TrapType = WinTrap ? tt_q : TT_NONE;
    assign CwpOut   = cwp_q;
    assign WimOut   = wim_q;
    assign EtOut    = et_q;
    assign ErrMode  = err_q;

`ifdef WINCTL_STATS_EN
    logic [15:0] ovf_q, ovf_d;
    logic [15:0] unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (WinTrap && (tt_q == TT_OVF) && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
        if (WinTrap && (tt_q == TT_UNF) && (unf_q != 16'hFFFF)) unf_d = unf_q + 16'd1;
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign OvfCnt = ovf_q;
    assign UnfCnt = unf_q;
`endif

endmodule

// File: tb/tb_window_control.sv
// Randomized self-checking bench for window_control against an arithmetic window-state model.
// Define WINCTL_STATS_EN to also check the trap counters.
module tb_window_control;

    localparam int NWIN = 4;

    logic       Clk = 1'b0;
    logic       Clr = 1'b1;
    logic       Req = 1'b0;
    logic [2:0] Cmd = 3'd0;
    logic [3:0] DataIn = 4'd0;
    logic       Ack, Busy, EtOut, WinTrap, ErrMode;
    logic [1:0] CwpOut, TrapType;
    logic [3:0] WimOut;
`ifdef WINCTL_STATS_EN
    logic [15:0] OvfCnt, UnfCnt;
`endif

    window_control dut (
        .Clk      (Clk),
        .Clr      (Clr),
        .Req      (Req),
        .Cmd      (Cmd),
        .DataIn   (DataIn),
        .Ack      (Ack),
        .Busy     (Busy),
        .CwpOut   (CwpOut),
        .WimOut   (WimOut),
        .EtOut    (EtOut),
        .WinTrap  (WinTrap),
        .TrapType (TrapType),
`ifdef WINCTL_STATS_EN
        .OvfCnt   (OvfCnt),
        .UnfCnt   (UnfCnt),
`endif
        .ErrMode  (ErrMode)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model of the architectural window state.
    int       m_cwp;
    logic [3:0] m_wim;
    bit       m_et, m_err;
    int       m_ovf, m_unf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cwp = 0; m_wim = 4'b0010; m_et = 1'b1; m_err = 1'b0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_cwp"}, 32'(CwpOut), 32'(m_cwp));
        check_eq({tag, "_wim"}, 32'(WimOut), 32'(m_wim));
        check_eq({tag, "_et"},  32'(EtOut),  32'(m_et));
        check_eq({tag, "_err"}, 32'(ErrMode), 32'(m_err));
`ifdef WINCTL_STATS_EN
        check_eq({tag, "_ovf"}, 32'(OvfCnt), 32'(m_ovf));
        check_eq({tag, "_unf"}, 32'(UnfCnt), 32'(m_unf));
`endif
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_ack"},  32'(Ack), 0);
        check_eq({tag, "_busy"}, 32'(Busy), 0);
        check_eq({tag, "_trap"}, 32'(WinTrap), 0);
        check_eq({tag, "_tt"},   32'(TrapType), 0);
        check_eq({tag, "_cwp0"}, 32'(CwpOut), 0);
        check_eq({tag, "_wim0"}, 32'(WimOut), 32'h2);
        check_eq({tag, "_et1"},  32'(EtOut), 1);
        check_eq({tag, "_err0"}, 32'(ErrMode), 0);
    endtask

    task automatic do_reset();
        Req = 1'b0;
        Clr = 1'b1;
        @(posedge Clk); #1;
        Clr = 1'b0;
        model_reset();
        check_reset("rst");
    endtask

    // One command through the handshake; hold keeps Req high past Ack (back-to-back).
    task automatic run_cmd(input logic [2:0] c, input logic [3:0] d, input bit hold);
        int nxt;
        int tt;
        Req = 1'b1; Cmd = c; DataIn = d;
        if (m_err) begin
            repeat (3) begin
                @(posedge Clk); #1;
                check_eq("ign_ack", 32'(Ack), 0);
                check_eq("ign_busy", 32'(Busy), 0);
            end
            Req = 1'b0;
            return;
        end
        if (c == 3'd1 || c == 3'd4) nxt = (m_cwp + NWIN - 1) % NWIN;
        else nxt = (m_cwp + 1) % NWIN;
        tt = 0;
        case (c)
            3'd1: if (m_wim[nxt]) tt = 1;
            3'd2: if (m_wim[nxt]) tt = 2;
            3'd5: if (!m_et && m_wim[nxt]) tt = 2;
            3'd4: if (!m_et) tt = 3;
            default: ;
        endcase

        @(posedge Clk); #1;
        check_eq("eval_busy", 32'(Busy), 1);
        check_eq("eval_ack", 32'(Ack), 0);
        @(posedge Clk); #1;
        check_eq("done_ack", 32'(Ack), 1);
        check_eq("done_busy", 32'(Busy), 1);
        check_eq("done_trap", 32'(WinTrap), 32'(tt != 0));
        check_eq("done_tt", 32'(TrapType), 32'(tt));
        check_eq("done_cwp_hold", 32'(CwpOut), 32'(m_cwp));
        if (!hold) Req = 1'b0;

        if (tt == 0) begin
            case (c)
                3'd1, 3'd2: m_cwp = nxt;
                3'd4: begin m_cwp = nxt; m_et = 1'b0; end
                3'd5: if (!m_et) begin m_cwp = nxt; m_et = 1'b1; end
                3'd3: m_wim = d;
                3'd6: m_cwp = int'(d) % NWIN;
                default: ;
            endcase
        end else if (tt == 3) begin
            m_err = 1'b1;
        end else if (tt == 1) begin
            if (m_ovf < 16'hFFFF) m_ovf++;
        end else begin
            if (m_unf < 16'hFFFF) m_unf++;
        end

        @(posedge Clk); #1;
        check_eq("post_ack", 32'(Ack), 0);
        check_eq("post_busy", 32'(Busy), 0);
        check_eq("post_trap", 32'(WinTrap), 0);
        check_state("post");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] c;
        logic [3:0] d;
        bit         h;

        model_reset();
        @(posedge Clk); #1;
        do_reset();

        // Reset then SAVE: 0 -> 3, no trap.
        run_cmd(3'd1, 4'd0, 1'b0);
        check_eq("t1_cwp3", 32'(CwpOut), 3);

        // RESTORE from 0 with WIM=0010: underflow, CWP stays.
        do_reset();
        run_cmd(3'd2, 4'd0, 1'b0);
        check_eq("t2_cwp0", 32'(CwpOut), 0);

        // WRWIM 0100, WRCWP 3, SAVE -> overflow into window 2.
        run_cmd(3'd3, 4'b0100, 1'b1);
        run_cmd(3'd6, 4'd3, 1'b1);
        run_cmd(3'd1, 4'd0, 1'b0);
        check_eq("t3_cwp3", 32'(CwpOut), 3);

        // WIM=1111: SAVE and RESTORE both trap.
        run_cmd(3'd3, 4'hF, 1'b0);
        run_cmd(3'd1, 4'd0, 1'b0);
        run_cmd(3'd2, 4'd0, 1'b0);

        // TRAPENT, then TRAPENT with ET=0 -> error mode; later Reqs ignored.
        do_reset();
        run_cmd(3'd4, 4'd0, 1'b0);
        check_eq("t4_cwp3", 32'(CwpOut), 3);
        check_eq("t4_et0", 32'(EtOut), 0);
        run_cmd(3'd4, 4'd0, 1'b0);
        check_eq("t4_errmode", 32'(ErrMode), 1);
        run_cmd(3'd1, 4'd0, 1'b0);

        // TRAPENT then RETT with WIM=0; then RETT with ET=1 is a NOP.
        do_reset();
        run_cmd(3'd3, 4'd0, 1'b0);
        run_cmd(3'd4, 4'd0, 1'b0);
        run_cmd(3'd5, 4'd0, 1'b0);
        check_eq("t5_cwp0", 32'(CwpOut), 0);
        check_eq("t5_et1", 32'(EtOut), 1);
        run_cmd(3'd5, 4'd0, 1'b0);

        // Clr during EVAL abandons the command.
        run_cmd(3'd6, 4'd2, 1'b0);
        Req = 1'b1; Cmd = 3'd1; DataIn = 4'd0;
        @(posedge Clk); #1;
        check_eq("clr_eval_busy", 32'(Busy), 1);
        Clr = 1'b1; Req = 1'b0;
        @(posedge Clk); #1;
        Clr = 1'b0;
        model_reset();
        check_reset("clr_eval");
        @(posedge Clk); #1;
        check_eq("clr_noack", 32'(Ack), 0);

        // Randomized command stream, with random back-to-back holds.
        for (int i = 0; i < 250; i++) begin
            if (m_err) begin
                run_cmd(3'($urandom_range(0, 7)), 4'($urandom), 1'b0);
                do_reset();
            end
            c = 3'($urandom_range(0, 7));
            d = 4'($urandom);
            if (c == 3'd3 && $urandom_range(0, 1) == 1) d = 4'd0;
            h = 1'($urandom_range(0, 1));
            run_cmd(c, d, h);
        end
        Req = 1'b0;
        @(posedge Clk); #1;
        check_state("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
